// File: rtl/serial_paralelo_sync.sv
// -----------------------------------------------------------------------------
// serial_paralelo_sync
//
// Per-lane serial-to-parallel receiver with COM-symbol framing. A bit-serial
// stream (MSB first) is deserialised into WIDTH-bit words. Word alignment is
// found by a sliding-window search for the COM symbol; after LOCK_COUNT
// consecutive aligned COMs the lane is declared active and data words are
// presented with a one-cycle valid strobe, while COM words raise an idle strobe.
//
// Optional feature macro: SERPAR_TIMEOUT_EN
//   When defined, a locked lane drops back to the search state after
//   TIMEOUT_WORDS consecutive non-COM words. When undefined, lock persists
//   until reset.
//
// Parameters:
//   WIDTH          word width in bits (>= 2)
//   COM            framing / idle symbol (must not be all zeros)
//   LOCK_COUNT     consecutive aligned COMs required to lock (>= 1)
//   TIMEOUT_WORDS  consecutive non-COM words that drop lock (timeout build only)
//
// Ports:
//   clk_32f    in   bit clock, rising edge
//   reset      in   asynchronous active-high reset
//   data_in    in   serial data bit, sampled every rising edge
//   out_word   out  last received data word (held between data words)
//   valid_out  out  one-cycle strobe, out_word carries a new data word
//   idle_out   out  one-cycle strobe, a COM was received while locked
//   active     out  lane is locked and aligned
// -----------------------------------------------------------------------------
module serial_paralelo_sync #(
   parameter int unsigned       WIDTH         = 8,
   parameter logic [WIDTH-1:0]  COM           = 8'hBC,
   parameter int unsigned       LOCK_COUNT    = 4,
   parameter int unsigned       TIMEOUT_WORDS = 16
) (
   input  logic             clk_32f,
   input  logic             reset,
   input  logic             data_in,
   output logic [WIDTH-1:0] out_word,
   output logic             valid_out,
   output logic             idle_out,
   output logic             active
);

   localparam int unsigned BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int unsigned CW = $clog2(LOCK_COUNT + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic [CW-1:0] LOCK_VAL = CW'(LOCK_COUNT);

`ifdef SERPAR_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_WORDS + 1);
   localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_WORDS);
`endif

   // Reject parameter sets the datapath cannot represent.
   if ((WIDTH < 32'd2) || (LOCK_COUNT < 32'd1) || (TIMEOUT_WORDS < 32'd1)) begin : g_param_check
      $error("serial_paralelo_sync: WIDTH>=2, LOCK_COUNT>=1, TIMEOUT_WORDS>=1 required");
   end

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t            state_r;
   // Only the WIDTH-1 most recent bits are stored: the last bit of every
   // candidate word comes straight from data_in on the evaluating edge.
   logic [WIDTH-2:0]  sr_r;
   logic [BW-1:0]     bit_cnt_r;
   logic [CW-1:0]     com_cnt_r;
`ifdef SERPAR_TIMEOUT_EN
   logic [TW-1:0]     to_cnt_r;
`endif

   logic [WIDTH-1:0]  word_s;
   logic              boundary_s;
   logic              is_com_s;

   // Symbol comparator kept as a helper so the framing test lives in one place.
   function automatic logic com_match(input logic [WIDTH-1:0] w);
      return (w == COM);
   endfunction

   // Candidate word, word-boundary flag and COM detection for this edge.
   always_comb begin
      word_s     = {sr_r, data_in};
      boundary_s = (bit_cnt_r == LAST_BIT);
      is_com_s   = com_match(word_s);
   end

   // Alignment FSM, shift register, counters and registered outputs.
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         state_r   <= SEARCH;
         sr_r      <= '0;
         bit_cnt_r <= '0;
         com_cnt_r <= '0;
`ifdef SERPAR_TIMEOUT_EN
         to_cnt_r  <= '0;
`endif
         out_word  <= '0;
         valid_out <= 1'b0;
         idle_out  <= 1'b0;
         active    <= 1'b0;
      end else begin
         sr_r      <= word_s[WIDTH-2:0];
         valid_out <= 1'b0;
         idle_out  <= 1'b0;

         if (boundary_s) begin
            bit_cnt_r <= '0;
         end else begin
            bit_cnt_r <= bit_cnt_r + BW'(1);
         end

`ifdef SERPAR_TIMEOUT_EN
         // The non-COM run only means something while locked.
         if (state_r != LOCKED) begin
            to_cnt_r <= '0;
         end else begin
            to_cnt_r <= to_cnt_r;
         end
`endif

         case (state_r)
            SEARCH: begin
               // Sliding window: every edge is a potential word end.
               if (is_com_s) begin
                  bit_cnt_r <= '0;
                  com_cnt_r <= CW'(1);
                  if (LOCK_COUNT == 32'd1) begin
                     state_r <= LOCKED;
                     active  <= 1'b1;
                  end else begin
                     state_r <= ALIGN;
                     active  <= 1'b0;
                  end
               end else begin
                  com_cnt_r <= '0;
                  active    <= 1'b0;
               end
            end

            ALIGN: begin
               // Only whole words on the acquired boundary are examined;
               // a single mismatch abandons the candidate alignment.
               if (boundary_s) begin
                  if (is_com_s) begin
                     if ((com_cnt_r + CW'(1)) == LOCK_VAL) begin
                        com_cnt_r <= LOCK_VAL;
                        state_r   <= LOCKED;
                        active    <= 1'b1;
                     end else begin
                        com_cnt_r <= com_cnt_r + CW'(1);
                     end
                  end else begin
                     com_cnt_r <= '0;
                     state_r   <= SEARCH;
                  end
               end else begin
                  com_cnt_r <= com_cnt_r;
               end
            end

            LOCKED: begin
               if (boundary_s) begin
                  if (is_com_s) begin
                     // COM words are idles and never surface as data.
                     idle_out <= 1'b1;
`ifdef SERPAR_TIMEOUT_EN
                     to_cnt_r <= '0;
`endif
                  end else begin
                     out_word  <= word_s;
                     valid_out <= 1'b1;
`ifdef SERPAR_TIMEOUT_EN
                     // The word that completes the run is still delivered;
                     // lock is dropped on the same edge.
                     if ((to_cnt_r + TW'(1)) >= TIMEOUT_VAL) begin
                        to_cnt_r  <= '0;
                        com_cnt_r <= '0;
                        state_r   <= SEARCH;
                        active    <= 1'b0;
                     end else begin
                        to_cnt_r  <= to_cnt_r + TW'(1);
                     end
`endif
                  end
               end else begin
                  active <= 1'b1;
               end
            end

            default: begin
               state_r   <= SEARCH;
               com_cnt_r <= '0;
               active    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// -----------------------------------------------------------------------------
// Self-checking bench for serial_paralelo_sync (WIDTH=8, COM=0xBC,
// LOCK_COUNT=4, TIMEOUT_WORDS=16). Directed steps follow the lane bring-up
// scenarios, then a randomized stream is compared cycle by cycle against a
// behavioural model of the framing rules.
// -----------------------------------------------------------------------------
module tb_serial_paralelo_sync;

   localparam int unsigned WIDTH   = 8;
   localparam logic [7:0]  COM     = 8'hBC;
   localparam int unsigned LOCK    = 4;
   localparam int unsigned TIMEOUT = 16;
`ifdef SERPAR_TIMEOUT_EN
   localparam logic TMO_ACTIVE = 1'b0;
`else
   localparam logic TMO_ACTIVE = 1'b1;
`endif

   logic             clk_32f;
   logic             reset;
   logic             data_in;
   logic [WIDTH-1:0] out_word;
   logic             valid_out;
   logic             idle_out;
   logic             active;

   int n_checks;
   int n_errors;

   // Behavioural model state
   int         m_win;
   bit         m_synced;
   bit         m_locked;
   int         m_ncom;
   int         m_left;
   int         m_run;
   logic       exp_valid;
   logic       exp_idle;
   logic [7:0] exp_word;

   serial_paralelo_sync #(
      .WIDTH(WIDTH), .COM(COM), .LOCK_COUNT(LOCK), .TIMEOUT_WORDS(TIMEOUT)
   ) dut (
      .clk_32f  (clk_32f),
      .reset    (reset),
      .data_in  (data_in),
      .out_word (out_word),
      .valid_out(valid_out),
      .idle_out (idle_out),
      .active   (active)
   );

   initial begin
      clk_32f = 1'b0;
      forever #5 clk_32f = ~clk_32f;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_win = 0; m_synced = 0; m_locked = 0; m_ncom = 0; m_left = 0; m_run = 0;
      exp_valid = 1'b0; exp_idle = 1'b0; exp_word = 8'h00;
   endtask

   // One received bit: window of the last WIDTH bits, framing by counting
   // bits since the first COM found.
   task automatic model_step(input logic b);
      m_win = ((m_win * 2) + int'(b)) % (1 << WIDTH);
      exp_valid = 1'b0;
      exp_idle  = 1'b0;
      if (!m_synced) begin
         if (m_win == int'(COM)) begin
            m_synced = 1; m_ncom = 1; m_left = WIDTH; m_run = 0;
            m_locked = (LOCK == 1);
         end
      end else begin
         m_left--;
         if (m_left == 0) begin
            m_left = WIDTH;
            if (m_locked) begin
               if (m_win == int'(COM)) begin
                  exp_idle = 1'b1; m_run = 0;
               end else begin
                  exp_valid = 1'b1; exp_word = 8'(m_win); m_run++;
`ifdef SERPAR_TIMEOUT_EN
                  if (m_run >= TIMEOUT) begin m_locked = 0; m_synced = 0; m_ncom = 0; end
`endif
               end
            end else if (m_win == int'(COM)) begin
               m_ncom++;
               if (m_ncom == LOCK) m_locked = 1;
            end else begin
               m_synced = 0; m_ncom = 0;
            end
         end
      end
   endtask

   task automatic send_bit(input logic b);
      data_in = b;
      @(posedge clk_32f);
      model_step(b);
      @(negedge clk_32f);
      check("active", active, m_locked);
      check("valid_out", valid_out, exp_valid);
      check("idle_out", idle_out, exp_idle);
      check("out_word", out_word, exp_word);
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i]);
   endtask

   // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
   task automatic do_reset(input string tag);
      #2 reset = 1'b1;
      #1;
      check({tag, "_active"}, active, 1'b0);
      check({tag, "_valid"}, valid_out, 1'b0);
      check({tag, "_idle"}, idle_out, 1'b0);
      check({tag, "_word"}, out_word, 8'h00);
      model_reset();
      @(negedge clk_32f);
      reset = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      data_in  = 1'b0;
      model_reset();
      @(negedge clk_32f);
      check("por_active", active, 1'b0);
      check("por_valid", valid_out, 1'b0);
      check("por_idle", idle_out, 1'b0);
      check("por_word", out_word, 8'h00);
      reset = 1'b0;

      // Lock acquisition after three junk bits
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      for (int i = 0; i < 3; i++) send_word(COM);
      check("pre_lock_active", active, 1'b0);
      send_word(COM);
      check("lock_active", active, 1'b1);

      // Locked data / idle / data
      send_word(8'hA5);
      check("data1_valid", valid_out, 1'b1);
      check("data1_word", out_word, 8'hA5);
      send_word(COM);
      check("idle_strobe", idle_out, 1'b1);
      check("idle_no_valid", valid_out, 1'b0);
      check("idle_hold_word", out_word, 8'hA5);
      send_word(8'h3C);
      check("data2_valid", valid_out, 1'b1);
      check("data2_word", out_word, 8'h3C);

      // Alignment failure then relock
      do_reset("rst_locked_a");
      send_word(COM); send_word(COM); send_word(8'h00);
      check("align_fail_active", active, 1'b0);
      for (int i = 0; i < 4; i++) send_word(COM);
      check("relock_active", active, 1'b1);

      // Timeout run of sixteen data words
      for (int i = 0; i < 15; i++) send_word(8'h55);
      check("tmo15_active", active, 1'b1);
      send_word(8'h55);
      check("tmo16_active", active, TMO_ACTIVE);
      check("tmo16_valid", valid_out, 1'b1);
      check("tmo16_word", out_word, 8'h55);

      // A COM after fifteen data words restarts the run
      do_reset("rst_tmo");
      for (int i = 0; i < 4; i++) send_word(COM);
      for (int i = 0; i < 15; i++) send_word(8'h55);
      send_word(COM);
      send_word(8'h55);
      check("tmo_cleared_active", active, 1'b1);

      // Reset mid-word while locked; relock needs a fresh set of COMs
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      do_reset("rst_midword");
      for (int i = 0; i < 3; i++) send_word(COM);
      check("fresh_3com_active", active, 1'b0);
      send_word(COM);
      check("fresh_4com_active", active, 1'b1);

      // Randomized stream: COM bursts, data words, bit slips
      for (int it = 0; it < 250; it++) begin
         int k;
         if (it == 120) do_reset("rst_random");
         k = $urandom_range(0, 3);
         case (k)
            0: begin
               int n;
               n = $urandom_range(4, 5);
               for (int i = 0; i < n; i++) send_word(COM);
            end
            1: send_word(8'($urandom_range(0, 255)));
            2: begin
               int n;
               n = $urandom_range(1, 3);
               for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
            end
            default: send_word(COM);
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
